// File: rtl/clk_en_pkg.sv
// Shared constants and types for the multi-channel clock-enable generator.
// The default ratios reproduce the master/4 PPU, /12 CPU and /24 APU enables.
package clk_en_pkg;

  localparam int DIV_PPU = 4;
  localparam int DIV_CPU = 12;
  localparam int DIV_APU = 24;

  localparam int DEF_NUM_CH = 3;
  localparam int DEF_DIV_W  = 8;

  // Channel 0 occupies the least-significant field.
  localparam logic [DEF_NUM_CH*DEF_DIV_W-1:0] DEF_DIVS =
    {8'(DIV_APU), 8'(DIV_CPU), 8'(DIV_PPU)};
  localparam logic [DEF_NUM_CH*DEF_DIV_W-1:0] DEF_PHASES = '0;

  typedef logic [2:0] ch_idx_t;

endpackage

// File: rtl/clk_en_chan.sv
// One enable channel: phase divider with deferred ratio reload, stall gating
// and the total/active event counters.
module clk_en_chan
  import clk_en_pkg::*;
#(
  parameter int               DIV_W     = 8,
  parameter int               CNT_W     = 64,
  parameter logic [DIV_W-1:0] DIV_RST   = 8'(DIV_PPU),
  parameter logic [DIV_W-1:0] PHASE_RST = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic             stall,
  input  logic             cnt_clr,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_val,
  output logic             clk_en,
  output logic             gated_en,
  output logic             cyc_par,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] active_cnt
);

  logic [DIV_W-1:0] d;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] pend;
  logic             pend_vld;
  logic             wrap;

  // A programmed ratio of zero behaves as ratio one.
  function automatic logic [DIV_W-1:0] eff_ratio(input logic [DIV_W-1:0] r);
    return (r == '0) ? DIV_W'(1) : r;
  endfunction

  assign wrap = (d == eff_ratio(div) - DIV_W'(1));

  // reset_n is folded in so the strobe drops immediately on async reset,
  // even if the reset phase happens to sit on the wrap value.
  assign clk_en   = reset_n & run & wrap;
  assign gated_en = clk_en & ~stall;
  assign cyc_par  = cycle_cnt[0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d          <= PHASE_RST;
      div        <= DIV_RST;
      pend       <= '0;
      pend_vld   <= 1'b0;
      cycle_cnt  <= '0;
      active_cnt <= '0;
    end else begin
      if (run) begin
        d <= wrap ? '0 : d + 1'b1;
        // New ratio only takes effect on a period boundary: no runt periods.
        if (wrap && pend_vld) begin
          div      <= pend;
          pend_vld <= 1'b0;
        end
      end
      // Placed after the reload so a write landing on a wrap stays pending.
      if (wr) begin
        pend     <= wr_val;
        pend_vld <= 1'b1;
      end
      if (cnt_clr) begin
        cycle_cnt  <= '0;
        active_cnt <= '0;
      end else begin
        if (clk_en)   cycle_cnt  <= cycle_cnt + 1'b1;
        if (gated_en) active_cnt <= active_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator: one clk_en_chan per channel plus the
// cross-channel alignment strobe.
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int                      NUM_CH = DEF_NUM_CH,
  parameter int                      DIV_W  = DEF_DIV_W,
  parameter int                      CNT_W  = 64,
  parameter logic [NUM_CH*DIV_W-1:0] DIVS   = DEF_DIVS,
  parameter logic [NUM_CH*DIV_W-1:0] PHASES = DEF_PHASES
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    run,
  input  logic [NUM_CH-1:0]       stall,
  input  logic                    cnt_clr,
  input  logic                    div_wr,
  input  logic [2:0]              div_ch,
  input  logic [DIV_W-1:0]        div_val,
  output logic [NUM_CH-1:0]       clk_en,
  output logic [NUM_CH-1:0]       gated_en,
  output logic [NUM_CH-1:0]       cyc_par,
  output logic                    align,
  output logic [NUM_CH*CNT_W-1:0] cycle_cnt,
  output logic [NUM_CH*CNT_W-1:0] active_cnt
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_wr;

    // Writes addressed beyond NUM_CH-1 match no channel and are dropped.
    assign ch_wr = div_wr & (ch_idx_t'(div_ch) == ch_idx_t'(i));

    clk_en_chan #(
      .DIV_W     (DIV_W),
      .CNT_W     (CNT_W),
      .DIV_RST   (DIVS[i*DIV_W +: DIV_W]),
      .PHASE_RST (PHASES[i*DIV_W +: DIV_W])
    ) u_chan (
      .clock      (clock),
      .reset_n    (reset_n),
      .run        (run),
      .stall      (stall[i]),
      .cnt_clr    (cnt_clr),
      .wr         (ch_wr),
      .wr_val     (div_val),
      .clk_en     (clk_en[i]),
      .gated_en   (gated_en[i]),
      .cyc_par    (cyc_par[i]),
      .cycle_cnt  (cycle_cnt[i*CNT_W +: CNT_W]),
      .active_cnt (active_cnt[i*CNT_W +: CNT_W])
    );
  end

  assign align = &clk_en;

endmodule

// File: tb/tb_clk_en_gen.sv
// Scoreboard bench for clk_en_gen: a default instance and a CNT_W=4 /
// ch0-phase-2 instance share stimulus and are checked against a period model.
module tb_clk_en_gen;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         run = 1'b0;
  logic [2:0]   stall = '0;
  logic         cnt_clr = 1'b0;
  logic         div_wr = 1'b0;
  logic [2:0]   div_ch = '0;
  logic [7:0]   div_val = '0;

  logic [2:0]   en0, ge0, par0;
  logic         al0;
  logic [191:0] cc0, ac0;
  logic [2:0]   en1, ge1, par1;
  logic         al1;
  logic [11:0]  cc1, ac1;

  clk_en_gen #(.CNT_W(64)) dut0 (
    .clock(clock), .reset_n(reset_n), .run(run), .stall(stall),
    .cnt_clr(cnt_clr), .div_wr(div_wr), .div_ch(div_ch), .div_val(div_val),
    .clk_en(en0), .gated_en(ge0), .cyc_par(par0), .align(al0),
    .cycle_cnt(cc0), .active_cnt(ac0));

  clk_en_gen #(.CNT_W(4), .PHASES(24'h000002)) dut1 (
    .clock(clock), .reset_n(reset_n), .run(run), .stall(stall),
    .cnt_clr(cnt_clr), .div_wr(div_wr), .div_ch(div_ch), .div_val(div_val),
    .clk_en(en1), .gated_en(ge1), .cyc_par(par1), .align(al1),
    .cycle_cnt(cc1), .active_cnt(ac1));

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]   en0, ge0, par0;
    logic         al0;
    logic [191:0] cc0, ac0;
    logic [2:0]   en1, ge1, par1;
    logic         al1;
    logic [11:0]  cc1, ac1;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cur_k = 0;
  int   align_seen = 0;
  logic [63:0] pmask0, pmask1;

  // Reference model: pulses occur where the run-cycle distance from the last
  // period anchor, offset by the start phase, lands on ratio-1.
  int          m_ratio[2][3];
  int          m_pend[2][3];
  bit          m_pvld[2][3];
  longint      m_base[2][3];
  int          m_sph[2][3];
  logic [63:0] m_cyc[2][3];
  logic [63:0] m_act[2][3];
  longint      m_rc;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", name, cur_k, act, req);
    end
  endtask

  task automatic model_reset();
    int divs[3] = '{4, 12, 24};
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 3; c++) begin
        m_ratio[i][c] = divs[c];
        m_pend[i][c]  = 0;
        m_pvld[i][c]  = 1'b0;
        m_base[i][c]  = 0;
        m_sph[i][c]   = (i == 1 && c == 0) ? 2 : 0;
        m_cyc[i][c]   = '0;
        m_act[i][c]   = '0;
      end
    m_rc = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; run = 1'b0; stall = '0; cnt_clr = 1'b0;
    div_wr = 1'b0; div_ch = '0; div_val = '0;
    #7;
    @(posedge clock); #1;
    reset_n = 1'b1;
    model_reset();
    cur_k = 0; pmask0 = '0; pmask1 = '0; align_seen = 0;
  endtask

  // Drives one cycle, pushes the expected outputs, advances the model.
  task automatic step(input logic r, input logic [2:0] st, input logic clr,
                      input logic wr, input logic [2:0] ch, input logic [7:0] val);
    exp_t x;
    int   e;
    int   pos;
    logic en[2][3];
    run = r; stall = st; cnt_clr = clr; div_wr = wr; div_ch = ch; div_val = val;
    x = '0;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 3; c++) begin
        e = (m_ratio[i][c] == 0) ? 1 : m_ratio[i][c];
        pos = int'((m_rc - m_base[i][c] + longint'(m_sph[i][c])) % longint'(e));
        en[i][c] = r && (pos == e - 1);
      end
    for (int c = 0; c < 3; c++) begin
      x.en0[c] = en[0][c];
      x.ge0[c] = en[0][c] & ~st[c];
      x.par0[c] = m_cyc[0][c][0];
      x.cc0[c*64 +: 64] = m_cyc[0][c];
      x.ac0[c*64 +: 64] = m_act[0][c];
      x.en1[c] = en[1][c];
      x.ge1[c] = en[1][c] & ~st[c];
      x.par1[c] = m_cyc[1][c][0];
      x.cc1[c*4 +: 4] = m_cyc[1][c][3:0];
      x.ac1[c*4 +: 4] = m_act[1][c][3:0];
    end
    x.al0 = en[0][0] & en[0][1] & en[0][2];
    x.al1 = en[1][0] & en[1][1] & en[1][2];
    sbq.push_back(x);
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 3; c++) begin
        if (clr) begin
          m_cyc[i][c] = '0;
          m_act[i][c] = '0;
        end else begin
          if (en[i][c]) m_cyc[i][c] = m_cyc[i][c] + 1;
          if (en[i][c] && !st[c]) m_act[i][c] = m_act[i][c] + 1;
        end
        if (en[i][c] && m_pvld[i][c]) begin
          m_ratio[i][c] = m_pend[i][c];
          m_base[i][c]  = m_rc + 1;
          m_sph[i][c]   = 0;
          m_pvld[i][c]  = 1'b0;
        end
        if (wr && int'(ch) == c) begin
          m_pend[i][c] = int'(val);
          m_pvld[i][c] = 1'b1;
        end
      end
    if (r) m_rc++;
    @(posedge clock); #1;
    cur_k++;
  endtask

  // Monitor: compares DUT outputs mid-cycle against the oldest expectation.
  exp_t mx;
  always @(negedge clock) begin
    if (sbq.size() > 0) begin
      mx = sbq.pop_front();
      check("clk_en0", 192'(en0), 192'(mx.en0));
      check("gated_en0", 192'(ge0), 192'(mx.ge0));
      check("cyc_par0", 192'(par0), 192'(mx.par0));
      check("align0", 192'(al0), 192'(mx.al0));
      check("cycle_cnt0", cc0, mx.cc0);
      check("active_cnt0", ac0, mx.ac0);
      check("clk_en1", 192'(en1), 192'(mx.en1));
      check("gated_en1", 192'(ge1), 192'(mx.ge1));
      check("align1", 192'(al1), 192'(mx.al1));
      check("cycle_cnt1", 192'(cc1), 192'(mx.cc1));
      check("active_cnt1", 192'(ac1), 192'(mx.ac1));
      if (cur_k < 64 && en0[0]) pmask0[cur_k] = 1'b1;
      if (cur_k < 64 && en1[0]) pmask1[cur_k] = 1'b1;
      if (al0) align_seen++;
    end
  end

  initial begin
    logic [63:0] m;

    // Strobes stay low during reset even with run asserted.
    run = 1'b1;
    #3;
    check("reset_clk_en", 192'({en0, en1}), 192'(0));
    check("reset_cnt", cc0 | ac0, 192'(0));

    // Default ratios, free running.
    do_reset();
    for (int k = 0; k < 48; k++) step(1, 3'b000, 0, 0, 3'd0, 8'd0);
    check("t1_cycle_cnt", cc0, {64'd2, 64'd4, 64'd12});
    check("t1_align_count", 192'(align_seen), 192'(2));
    m = '0;
    for (int j = 3; j < 48; j += 4) m[j] = 1'b1;
    check("t1_ch0_pulses", 192'(pmask0), 192'(m));

    // Stall on channel 1 for the first 24 cycles.
    do_reset();
    for (int k = 0; k < 30; k++) begin
      if (k == 24) begin
        check("t2_cycle_cnt1", 192'(cc0[127:64]), 192'(2));
        check("t2_active_cnt1", 192'(ac0[127:64]), 192'(0));
      end
      step(1, (k < 24) ? 3'b010 : 3'b000, 0, 0, 3'd0, 8'd0);
    end

    // Runtime ratio write mid-period.
    do_reset();
    for (int k = 0; k < 17; k++) step(1, 3'b000, 0, k == 5, 3'd0, 8'd3);
    m = (64'd1 << 3) | (64'd1 << 7) | (64'd1 << 10) | (64'd1 << 13) | (64'd1 << 16);
    check("t3_write_mid", 192'(pmask0), 192'(m));

    // Write landing on a wrap cycle waits for the following wrap.
    do_reset();
    for (int k = 0; k < 15; k++) step(1, 3'b000, 0, k == 7, 3'd0, 8'd3);
    m = (64'd1 << 3) | (64'd1 << 7) | (64'd1 << 11) | (64'd1 << 14);
    check("t3_write_on_wrap", 192'(pmask0), 192'(m));

    // Freeze for cycles 5..9 and an out-of-range write.
    do_reset();
    for (int k = 0; k < 14; k++)
      step(!(k >= 5 && k <= 9), 3'b000, 0, k == 2, 3'd5, 8'd1);
    m = (64'd1 << 3) | (64'd1 << 12);
    check("t4_freeze", 192'(pmask0), 192'(m));

    // Phase-2 channel, then ratio 0 (every cycle) after the next wrap.
    do_reset();
    for (int k = 0; k < 10; k++) step(1, 3'b000, 0, k == 2, 3'd0, 8'd0);
    m = (64'd1 << 1) | (64'd1 << 5) | (64'd1 << 6) | (64'd1 << 7) | (64'd1 << 8) | (64'd1 << 9);
    check("t5_phase_ratio0", 192'(pmask1), 192'(m));

    // 4-bit counter wrap and clear-beats-increment.
    do_reset();
    for (int k = 0; k < 67; k++) begin
      if (k == 61) check("t6_cnt_before_wrap", 192'(cc1[3:0]), 192'(15));
      if (k == 62) check("t6_cnt_wrapped", 192'(cc1[3:0]), 192'(0));
      if (k == 66) check("t6_clr_vs_pulse", 192'(cc1[3:0]), 192'(0));
      step(1, 3'b000, k == 65, 0, 3'd0, 8'd0);
    end

    // Randomised traffic.
    do_reset();
    for (int k = 0; k < 1500; k++)
      step(($urandom % 8) != 0, 3'($urandom), ($urandom % 20) == 0,
           ($urandom % 10) == 0, 3'($urandom), 8'($urandom % 30));

    // Asynchronous reset mid-count, observed before any clock edge.
    run = 1'b1;
    reset_n = 1'b0;
    #2;
    check("async_rst_strobes", 192'({en0, ge0, par0, al0, en1, ge1, par1, al1}), 192'(0));
    check("async_rst_cnt0", cc0 | ac0, 192'(0));
    check("async_rst_cnt1", 192'({cc1, ac1}), 192'(0));

    do_reset();
    for (int k = 0; k < 600; k++)
      step(($urandom % 6) != 0, 3'($urandom), ($urandom % 25) == 0,
           ($urandom % 8) == 0, 3'($urandom), 8'($urandom % 6));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_en_gen.md
Name: clk_en_gen

Overview:
- Parametrised multi-channel clock-enable generator with per-channel event counters; replaces the fixed single-ratio dividers (master/4 PPU, /12 CPU, /24 APU) and the ad-hoc cycle counters in the full-system top.
- Generates NUM_CH single-cycle enable strobes from the master clock. Each channel has its own divide ratio, phase offset, stall gating and runtime-reprogrammable ratio.
- Also provides per-channel total/active event counts, cycle parity, and a cross-channel alignment strobe for DMA timing and trace logging.

Parameters:
- NUM_CH, 3, number of enable channels (1..8).
- DIV_W, 8, width of each divide-ratio field.
- CNT_W, 64, width of each event counter.
- DIVS, {8'd24, 8'd12, 8'd4}, packed NUM_CH*DIV_W reset divide ratios; channel i is DIVS[i*DIV_W +: DIV_W].
- PHASES, {8'd0, 8'd0, 8'd0}, packed initial divider count per channel; each must be < its DIVS field.

Ports:
- clock, input, 1, master clock.
- reset_n, input, 1, asynchronous active-low reset.
- run, input, 1, global run: 1 = dividers advance, 0 = freeze.
- stall, input, NUM_CH, per-channel suspend (e.g. CPU suspended during OAMDMA).
- cnt_clr, input, 1, synchronous clear of all event counters.
- div_wr, input, 1, runtime divide-ratio write strobe.
- div_ch, input, 3, target channel of the write.
- div_val, input, DIV_W, new divide ratio.
- clk_en, output, NUM_CH, raw enable strobe per channel.
- gated_en, output, NUM_CH, clk_en & ~stall.
- cyc_par, output, NUM_CH, bit 0 of the channel's cycle_cnt.
- align, output, 1, high when all clk_en bits are high in the same cycle.
- cycle_cnt, output, NUM_CH*CNT_W, count of clk_en pulses per channel.
- active_cnt, output, NUM_CH*CNT_W, count of gated_en pulses per channel.

Behaviour:
- Cycle k is the k-th clock period after reset_n deasserts (k=0 first).
- Reset (async, immediate on reset_n low):
  - divider d[i]=PHASES[i]; div[i]=DIVS[i]; pending-write valid cleared.
  - all counters 0; clk_en, gated_en, align, cyc_par all 0.
- Effective ratio: e[i] = (div[i]==0) ? 1 : div[i]. Ratio 1 means clk_en is high every run cycle.
- Divider, when run=1:
  - d[i] increments each clock.
  - In a cycle where d[i]==e[i]-1, d[i] wraps to 0 next cycle.
  - Example: PHASE 0, ratio 4 gives pulses at cycles 3, 7, 11, ...
- clk_en[i] = run & (d[i]==e[i]-1). This is a combinational decode of registered state; no extra latency.
- run=0: d[i] holds and all strobes are 0. On resume, the count continues from the held value (no re-phase).
- stall gating:
  - stall[i] gates only gated_en and active_cnt.
  - d[i] and cycle_cnt keep advancing, so a stalled channel stays in phase.
- Counters:
  - cycle_cnt[i] += 1 on clk_en[i]; active_cnt[i] += 1 on gated_en[i].
  - Both wrap modulo 2^CNT_W.
  - cnt_clr takes priority over an increment in the same cycle (result is 0); dividers are unaffected.
- Runtime ratio write:
  - div_wr with div_ch < NUM_CH stores div_val into the channel's pending register and sets pending-valid.
  - div_ch >= NUM_CH is ignored.
  - A second write before the pending value is applied overwrites it (latest wins).
  - The pending value is applied at the channel's next wrap: in a cycle with clk_en[i]=1 and pending-valid=1, div[i] loads the pending value, d[i] goes to 0, and pending-valid clears.
  - This avoids runt or over-long periods.
  - A write in the same cycle as a wrap is captured into pending and applied at the following wrap.
  - Writes while run=0 are accepted and remain pending.
- align = &clk_en, combinational.
- All register state sits in a single always_ff block with async reset; there are no other clocks.

Decomposition:
- Package clk_en_pkg holds:
  - localparams DIV_PPU=4, DIV_CPU=12, DIV_APU=24;
  - the default DIVS/PHASES vectors;
  - typedef for the channel index type.
- One sub-module, clk_en_chan: divider, pending-ratio register, two counters and gating for a single channel.
- The top generates NUM_CH instances of clk_en_chan and computes align.

Test Plan:
1. Defaults, run=1 for 48 cycles:
   - ch0 (/4) pulses at 3, 7, ..., 47 (12 pulses); ch1 (/12) at 11, 23, 35, 47; ch2 (/24) at 23, 47.
   - align high only at 23 and 47.
   - cycle_cnt = {2, 4, 12}.
2. stall[1]=1 for cycles 0..23:
   - cycle_cnt[1]=2 and active_cnt[1]=0 at cycle 24; gated_en[1] never high; clk_en[1] high at 11 and 23.
3. Runtime write div_ch=0, div_val=3 at cycle 5:
   - ch0 pulses at 3, 7 (old ratio), then 10, 13, 16.
   - A write at cycle 7, coinciding with the wrap, applies after the pulse at 11.
4. run=0 at cycles 5..9, then run=1:
   - ch0 pulses at 3, then 12 (frozen 5 cycles); no strobes while frozen.
   - Also: div_ch=5 with div_wr causes no change.
5. PHASES ch0=2, ratio 4:
   - first pulse at cycle 1, then 5, 9.
   - With div_val=0 written, after the next wrap ch0 pulses every cycle.
6. Reset and wrap:
   - Assert reset_n low mid-count; all outputs 0 within the same cycle, with no clock edge.
   - Then override CNT_W=4: 16 ch0 pulses wrap cycle_cnt[0] to 0; cnt_clr concurrent with a pulse gives 0.
